// File: rtl/mmio_uart_tx_pkg.sv
// Shared types, register offsets and STATUS layout for the memory-mapped UART transmitter.
package mmio_uart_tx_pkg;

    typedef enum logic [1:0] {
        UART_IDLE,
        UART_START,
        UART_DATA,
        UART_STOP
    } uart_state_t;

    localparam logic [1:0] UART_REG_TXDATA = 2'd0;
    localparam logic [1:0] UART_REG_STATUS = 2'd1;
    localparam logic [1:0] UART_REG_DIV    = 2'd2;

    localparam int STAT_FULL    = 0;
    localparam int STAT_EMPTY   = 1;
    localparam int STAT_ACTIVE  = 2;
    localparam int STAT_OVF     = 3;
    localparam int STAT_CNT_LSB = 4;
    localparam int STAT_CNT_W   = 4;

    function automatic logic [31:0] pack_status(
        input logic                  full,
        input logic                  empty,
        input logic                  active,
        input logic                  ovf,
        input logic [STAT_CNT_W-1:0] count
    );
        logic [31:0] s;
        s                              = '0;
        s[STAT_FULL]                   = full;
        s[STAT_EMPTY]                  = empty;
        s[STAT_ACTIVE]                 = active;
        s[STAT_OVF]                    = ovf;
        s[STAT_CNT_LSB +: STAT_CNT_W]  = count;
        return s;
    endfunction

endpackage

// File: rtl/mmio_uart_tx_if.sv
// Load/store port between the core's MMIO decode and the UART register file.
interface mmio_uart_tx_if;
    import mmio_uart_tx_pkg::*;

    logic        i_wr_en;
    logic        i_rd_en;
    logic [1:0]  i_addr;
    logic [31:0] i_wdata;
    logic [31:0] o_rdata;

    modport master (output i_wr_en, output i_rd_en, output i_addr, output i_wdata, input o_rdata);
    modport slave  (input i_wr_en, input i_rd_en, input i_addr, input i_wdata, output o_rdata);

endinterface

// File: rtl/mmio_uart_tx_fifo.sv
// Synchronous TX byte FIFO; a push into a full FIFO is still accepted when a pop frees a slot the same cycle.
module mmio_uart_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_push,
    input  logic                         i_pop,
    input  logic [WIDTH-1:0]             i_data,
    output logic [WIDTH-1:0]             o_data,
    output logic                         o_full,
    output logic                         o_empty,
    output logic                         o_drop,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));
    assign w_pop   = i_pop & ~o_empty;
    assign w_push  = i_push & (~o_full | w_pop);
    assign o_drop  = i_push & ~w_push;
    assign o_data  = r_mem[r_rptr];
    assign o_count = r_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    // pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: register decode, TX FIFO, baud down-counter and frame FSM.
//  state | meaning
//  IDLE  | line high, waiting for a queued byte
//  START | start bit (low) for DIV cycles
//  DATA  | eight data bits LSB first, DIV cycles each
//  STOP  | stop bit (high); chains straight into START if more bytes are queued
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int DIV_DEFAULT = 868,
    parameter int DIV_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mmio_uart_tx_if.slave         bus,
    output logic                  o_tx,
    output logic                  o_irq
);
    localparam int CW = $clog2(FIFO_DEPTH+1);

    localparam logic [1:0] S_IDLE  = UART_IDLE;
    localparam logic [1:0] S_START = UART_START;
    localparam logic [1:0] S_DATA  = UART_DATA;
    localparam logic [1:0] S_STOP  = UART_STOP;

    logic [1:0]       r_state;
    logic [DIV_W-1:0] r_cnt;
    logic [2:0]       r_idx;
    logic [7:0]       r_shift;
    logic [DIV_W-1:0] r_div;
    logic             r_ovf;
    logic             r_irq;
    logic [31:0]      r_rdata;

    logic             w_push_req;
    logic             w_pop;
    logic             w_bit_end;
    logic [7:0]       w_fifo_data;
    logic             w_full;
    logic             w_empty;
    logic             w_drop;
    logic [CW-1:0]    w_count;
    logic [DIV_W-1:0] w_div_wdata;
    logic [DIV_W-1:0] w_div_next;
    logic [DIV_W-1:0] w_reload;
    logic             w_active;
    logic             w_tx;
    logic             w_unused_wdata;

    assign w_push_req     = bus.i_wr_en && (bus.i_addr == UART_REG_TXDATA);
    assign w_bit_end      = (r_cnt == '0);
    assign w_pop          = ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end)) && !w_empty;
    assign w_reload       = r_div - DIV_W'(1);
    assign w_active       = (r_state != S_IDLE);
    assign w_div_wdata    = bus.i_wdata[DIV_W-1:0];
    assign w_div_next     = (w_div_wdata == '0) ? DIV_W'(1) : w_div_wdata;
    assign w_unused_wdata = ^bus.i_wdata;

    mmio_uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push_req),
        .i_pop   (w_pop),
        .i_data  (bus.i_wdata[7:0]),
        .o_data  (w_fifo_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_drop  (w_drop),
        .o_count (w_count)
    );

    // the reload always uses the live DIV, so a mid-frame write lands on the next bit boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_shift <= w_fifo_data;
                        r_cnt   <= w_reload;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_cnt   <= w_reload;
                        r_idx   <= '0;
                        r_state <= S_DATA;
                    end else begin
                        r_cnt <= r_cnt - DIV_W'(1);
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_cnt   <= w_reload;
                        r_shift <= {1'b0, r_shift[7:1]};
                        r_idx   <= r_idx + 3'd1;
                        if (r_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt - DIV_W'(1);
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        if (w_pop) begin
                            r_shift <= w_fifo_data;
                            r_cnt   <= w_reload;
                            r_state <= S_START;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt - DIV_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_tx = 1'b1;
        case (r_state)
            S_START: w_tx = 1'b0;
            S_DATA:  w_tx = r_shift[0];
            default: w_tx = 1'b1;
        endcase
    end

    // a drop in the same cycle as a STATUS read wins, so no overflow is ever lost
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div   <= DIV_W'(DIV_DEFAULT);
            r_ovf   <= 1'b0;
            r_irq   <= 1'b1;
            r_rdata <= '0;
        end else begin
            r_irq <= w_empty & ~w_active;
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (bus.i_rd_en && (bus.i_addr == UART_REG_STATUS)) begin
                r_ovf <= 1'b0;
            end
            if (bus.i_wr_en && (bus.i_addr == UART_REG_DIV)) begin
                r_div <= w_div_next;
            end
            if (bus.i_rd_en) begin
                case (bus.i_addr)
                    UART_REG_STATUS: r_rdata <= pack_status(w_full, w_empty, w_active, r_ovf,
                                                            STAT_CNT_W'(w_count));
                    UART_REG_DIV:    r_rdata <= 32'(r_div);
                    default:         r_rdata <= '0;
                endcase
            end
        end
    end

    assign bus.o_rdata = r_rdata;
    assign o_tx        = w_tx;
    assign o_irq       = r_irq;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: random and directed MMIO traffic against a frame-timing queue model, with a serial receiver and read scoreboard.
module tb_mmio_uart_tx;
    import mmio_uart_tx_pkg::*;

    localparam int DEPTH   = 8;
    localparam int DIV_DEF = 868;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic tx;
    logic irq;

    always #5 clk = ~clk;

    mmio_uart_tx_if bus();

    mmio_uart_tx #(
        .FIFO_DEPTH  (DEPTH),
        .DIV_DEFAULT (DIV_DEF),
        .DIV_W       (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .o_tx  (tx),
        .o_irq (irq)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // reference model: FIFO occupancy plus cycles left in the frame on the wire
    int          m_cnt  = 0;
    int          m_rem  = 0;
    logic        m_ovf  = 1'b0;
    int          m_div  = DIV_DEF;
    logic        m_irq  = 1'b1;
    bit          sb_en  = 1'b1;
    bit          rx_en  = 1'b1;
    bit          rd_seen = 1'b0;
    logic [7:0]  exp_tx[$];
    logic [31:0] exp_rd[$];
    int          rx_starts[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_cnt = 0; m_rem = 0; m_ovf = 1'b0; m_div = DIV_DEF; m_irq = 1'b1;
            rd_seen = 1'b0;
            exp_tx.delete();
            exp_rd.delete();
        end else begin
            bit pop, push, acc, irq_next;
            logic [31:0] rv;
            pop      = (m_rem <= 1) && (m_cnt > 0);
            push     = bus.i_wr_en && (bus.i_addr == UART_REG_TXDATA);
            acc      = push && ((m_cnt < DEPTH) || pop);
            irq_next = (m_cnt == 0) && (m_rem == 0);
            rd_seen  = bus.i_rd_en;
            if (bus.i_rd_en) begin
                case (bus.i_addr)
                    UART_REG_STATUS: rv = {24'b0, 4'(m_cnt), m_ovf, (m_rem != 0), (m_cnt == 0), (m_cnt == DEPTH)};
                    UART_REG_DIV:    rv = 32'(m_div);
                    default:         rv = 32'b0;
                endcase
                exp_rd.push_back(rv);
            end
            if (push && !acc) m_ovf = 1'b1;
            else if (bus.i_rd_en && bus.i_addr == UART_REG_STATUS) m_ovf = 1'b0;
            if (acc && sb_en) exp_tx.push_back(bus.i_wdata[7:0]);
            if (pop) m_rem = 10 * m_div;
            else if (m_rem > 0) m_rem = m_rem - 1;
            if (bus.i_wr_en && bus.i_addr == UART_REG_DIV)
                m_div = (bus.i_wdata[15:0] == 16'd0) ? 1 : int'(bus.i_wdata[15:0]);
            m_cnt = m_cnt + (acc ? 1 : 0) - (pop ? 1 : 0);
            m_irq = irq_next;
        end
    end

    // read scoreboard, irq and idle-line monitor
    initial forever begin
        @(negedge clk);
        if (rst_n && rd_seen) begin
            if (exp_rd.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL rdata: unexpected read response 0x%0h", bus.o_rdata);
            end else begin
                chk("rdata", bus.o_rdata, exp_rd.pop_front());
            end
        end
        if (rst_n && sb_en) begin
            chk("irq", irq, m_irq);
            if (m_rem == 0) chk("tx_idle", tx, 1'b1);
        end
    end

    // serial receiver: samples mid-bit and pops the expected byte
    initial forever begin
        @(negedge clk);
        if (rx_en && rst_n && tx === 1'b0) begin
            int d;
            logic [7:0] b;
            d = m_div;
            b = 8'h00;
            rx_starts.push_back(cyc);
            for (int s = 1; s < 10 * d; s++) begin
                @(negedge clk);
                if (s == d - 1) chk("start_bit", tx, 1'b0);
                if (s >= d && s < 9 * d && (s % d) == d / 2) b[s / d - 1] = tx;
                if (s == 9 * d + d / 2) chk("stop_bit", tx, 1'b1);
            end
            if (exp_tx.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL rx_byte: got 0x%0h want none", b);
            end else begin
                chk("rx_byte", b, exp_tx.pop_front());
            end
        end
    end

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.i_wr_en = 1'b1; bus.i_addr = a; bus.i_wdata = d;
        @(negedge clk);
        bus.i_wr_en = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a);
        bus.i_rd_en = 1'b1; bus.i_addr = a;
        @(negedge clk);
        bus.i_rd_en = 1'b0;
    endtask

    task automatic wrrd(input logic [1:0] a, input logic [31:0] d);
        bus.i_wr_en = 1'b1; bus.i_rd_en = 1'b1; bus.i_addr = a; bus.i_wdata = d;
        @(negedge clk);
        bus.i_wr_en = 1'b0; bus.i_rd_en = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((m_cnt != 0 || m_rem != 0) && k < 20000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 20000) begin
            n_vec++; n_err++;
            $display("FAIL drain: timeout after %0d cycles", k);
        end
        repeat (3) @(negedge clk);
    endtask

    function automatic bit model_idle();
        return (m_cnt == 0) && (m_rem == 0);
    endfunction

    logic rec [140];
    int   exp_len [9] = '{4, 4, 8, 8, 8, 8, 8, 8, 8};

    initial begin
        bus.i_wr_en = 1'b0; bus.i_rd_en = 1'b0; bus.i_addr = 2'd0; bus.i_wdata = 32'd0;
        repeat (3) @(negedge clk);
        chk("reset_tx", tx, 1'b1);
        chk("reset_irq", irq, 1'b1);
        chk("reset_rdata", bus.o_rdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        rd(UART_REG_STATUS);
        rd(UART_REG_DIV);

        // single 0x55 frame at DIV=4
        wr(UART_REG_DIV, 32'd4);
        wr(UART_REG_TXDATA, 32'h55);
        drain();

        // back-to-back frames: no idle gap between stop and next start
        rx_starts.delete();
        wr(UART_REG_TXDATA, 32'hA5);
        wr(UART_REG_TXDATA, 32'h3C);
        drain();
        chk("b2b_frames", rx_starts.size(), 2);
        if (rx_starts.size() == 2) chk("b2b_gap", rx_starts[1] - rx_starts[0], 40);

        // DIV=0 is stored as 1, giving 10-cycle frames
        wr(UART_REG_DIV, 32'd0);
        rd(UART_REG_DIV);
        rx_starts.delete();
        wr(UART_REG_TXDATA, 32'hFF);
        wr(UART_REG_TXDATA, 32'h00);
        drain();
        chk("div1_frames", rx_starts.size(), 2);
        if (rx_starts.size() == 2) chk("div1_frame_len", rx_starts[1] - rx_starts[0], 10);

        // burst of 10 at DIV=4: the 10th hits a full FIFO; STATUS clears overflow
        wr(UART_REG_DIV, 32'd4);
        for (int i = 0; i < 10; i++) wr(UART_REG_TXDATA, 32'(8'h10 + i));
        rd(UART_REG_STATUS);
        rd(UART_REG_STATUS);
        drain();

        // simultaneous read and write on a full FIFO
        for (int i = 0; i < 9; i++) wr(UART_REG_TXDATA, 32'(8'h60 + i));
        wrrd(UART_REG_TXDATA, 32'h77);
        wrrd(UART_REG_STATUS, 32'hFFFF_FFFF);
        rd(UART_REG_STATUS);
        drain();

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            int op;
            logic [1:0] a;
            op = $urandom_range(0, 9);
            case (op)
                0, 1, 2, 3: wr(UART_REG_TXDATA, $urandom());
                4: rd(UART_REG_STATUS);
                5: rd(2'($urandom_range(0, 3)));
                6: begin
                    a = 2'($urandom_range(0, 3));
                    if (a == UART_REG_DIV && !model_idle()) a = UART_REG_STATUS;
                    if (a == UART_REG_DIV) wrrd(a, ($urandom() & 32'hFFFF_0000) | $urandom_range(0, 5));
                    else wrrd(a, $urandom());
                end
                7: wr(2'd3, $urandom());
                8: begin
                    if (model_idle()) wr(UART_REG_DIV, ($urandom() & 32'hFFFF_0000) | $urandom_range(0, 5));
                    else rd(UART_REG_DIV);
                end
                default: repeat ($urandom_range(1, 40)) @(negedge clk);
            endcase
        end
        drain();
        chk("pending_bytes", exp_tx.size(), 0);

        // DIV raised during data bit 0: bit 0 keeps 4 cycles, later bits take 8
        rx_en = 1'b0;
        sb_en = 1'b0;
        wr(UART_REG_DIV, 32'd4);
        wr(UART_REG_TXDATA, 32'h55);
        fork
            begin
                for (int i = 0; i < 140; i++) begin
                    @(negedge clk);
                    rec[i] = tx;
                end
            end
            begin
                repeat (6) @(negedge clk);
                wr(UART_REG_DIV, 32'd8);
            end
        join
        begin
            int p;
            int len;
            logic v;
            p = 0;
            while (p < 140 && rec[p] == 1'b1) p++;
            for (int r = 0; r < 9; r++) begin
                v = (p < 140) ? rec[p] : 1'bx;
                len = 0;
                while (p < 140 && rec[p] == v) begin
                    len++;
                    p++;
                end
                chk("run_len", len, exp_len[r]);
                chk("run_val", v, (r % 2 == 0) ? 1'b0 : 1'b1);
            end
            len = 0;
            while (p < 140 && rec[p] == 1'b1) begin
                len++;
                p++;
            end
            chk("stop_run", (len >= 8) ? 1 : 0, 1);
        end
        repeat (10) @(negedge clk);

        // async reset in the middle of a 0x00 frame
        wr(UART_REG_TXDATA, 32'h00);
        repeat (30) @(negedge clk);
        chk("tx_in_data", tx, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_tx", tx, 1'b1);
        chk("async_rst_irq", irq, 1'b1);
        chk("async_rst_rdata", bus.o_rdata, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        sb_en = 1'b1;
        rx_en = 1'b1;
        rd(UART_REG_STATUS);
        rd(UART_REG_DIV);
        repeat (5) @(negedge clk);
        chk("pending_reads", exp_rd.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
